// File: rtl/lru_cache_pkg.sv
// Shared definitions for the LRU cache controller: line geometry and FSM states.
// Stats counters are enabled by defining LRU_CTRL_STATS_EN.
package lru_cache_pkg;

  localparam int NUM_LINES = 4;
  localparam int IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    RESP
  } state_e;

endpackage

// File: rtl/lru_tag_store.sv
// Four tag/valid registers with a parallel tag compare
// and lowest-index invalid-line search.
module lru_tag_store
  import lru_cache_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [TAG_W-1:0] cmp_tag,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic             inv_any,
  output logic [IDX_W-1:0] inv_idx
);

  logic [NUM_LINES-1:0][TAG_W-1:0] tags_q, tags_d;
  logic [NUM_LINES-1:0]            valid_q, valid_d;

  always_comb begin
    tags_d  = tags_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = '0;
    end else if (wr_en) begin
      tags_d[wr_idx]  = wr_tag;
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tags_q  <= '0;
      valid_q <= '0;
    end else begin
      tags_q  <= tags_d;
      valid_q <= valid_d;
    end
  end

  // A tag is only written on a miss, so at most one line can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && tags_q[i] == cmp_tag) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    inv_any = ~&valid_q;
    inv_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!valid_q[i]) inv_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/lru_cache_ctrl.sv
// Lookup/refill controller for a 4-line fully associative cache.
// Define LRU_CTRL_STATS_EN to add saturating hit/miss counters.
module lru_cache_ctrl
  import lru_cache_pkg::*;
#(
  parameter int TAG_W       = 8,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  input  logic             flush,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [1:0]       resp_line,
  input  logic [1:0]       victim_line,
  output logic             upd_valid,
  output logic             upd_hit,
  output logic [1:0]       upd_line,
  output logic             mem_req,
  output logic [TAG_W-1:0] mem_tag,
  input  logic             mem_ack,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
);

  // MEM_TIMEOUT is reserved; it is consumed here and drives nothing.
  logic unused_timeout;
  assign unused_timeout = (MEM_TIMEOUT != 0);

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   line_q, line_d;
  logic               hit_q, hit_d;

  logic               ts_clear, ts_wr;
  logic               ts_hit, ts_inv_any;
  logic [IDX_W-1:0]   ts_hit_idx, ts_inv_idx;

  lru_tag_store #(.TAG_W(TAG_W)) u_tags (
    .clk     (clk),
    .reset   (reset),
    .clear   (ts_clear),
    .wr_en   (ts_wr),
    .wr_idx  (line_q),
    .wr_tag  (tag_q),
    .cmp_tag (tag_q),
    .hit     (ts_hit),
    .hit_idx (ts_hit_idx),
    .inv_any (ts_inv_any),
    .inv_idx (ts_inv_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      line_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    line_d  = line_q;
    hit_d   = hit_q;
    unique case (state_q)
      IDLE: begin
        if (!flush && req_valid) begin
          tag_d   = req_tag;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (ts_hit) begin
          line_d  = ts_hit_idx;
          hit_d   = 1'b1;
          state_d = RESP;
        end else begin
          line_d  = ts_inv_any ? ts_inv_idx : victim_line;
          hit_d   = 1'b0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_ack) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    mem_req    = (state_q == REFILL);
    resp_hit   = resp_valid & hit_q;
    resp_line  = resp_valid ? line_q : '0;
    upd_valid  = resp_valid;
    upd_hit    = resp_hit;
    upd_line   = resp_line;
    mem_tag    = mem_req ? tag_q : '0;
    ts_clear   = req_ready & flush;
    ts_wr      = mem_req & mem_ack;
  end

`ifdef LRU_CTRL_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == RESP) begin
      if (hit_q) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_lru_cache_ctrl.sv
// Bench for lru_cache_ctrl: tag-array model, per-cycle response compare,
// and directed scenarios with literal expectations.
module tb_lru_cache_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_tag;
  logic       req_ready;
  logic       flush;
  logic       resp_valid, resp_hit;
  logic [1:0] resp_line;
  logic [1:0] victim_line;
  logic       upd_valid, upd_hit;
  logic [1:0] upd_line;
  logic       mem_req;
  logic [7:0] mem_tag;
  logic       mem_ack;
  logic [15:0] hit_count, miss_count;

  lru_cache_ctrl #(.TAG_W(8), .MEM_TIMEOUT(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_tag     (req_tag),
    .req_ready   (req_ready),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_line   (resp_line),
    .victim_line (victim_line),
    .upd_valid   (upd_valid),
    .upd_hit     (upd_hit),
    .upd_line    (upd_line),
    .mem_req     (mem_req),
    .mem_tag     (mem_tag),
    .mem_ack     (mem_ack),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       hit;
    bit [1:0] line;
    int       due;
  } exp_t;

  exp_t     exp_q[$];
  int       cyc = 0;
  int       n_cmp = 0;
  int       n_bad = 0;
  bit [7:0] m_tag[4];
  bit       m_vld[4];
  int       m_hits = 0;
  int       m_miss = 0;
  bit       last_hit;
  bit [1:0] last_line;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle check of responses, update mirror and statistics.
  always @(negedge clk) begin
    if (!reset) begin
      chk(hit_count == 16'(m_hits) && miss_count == 16'(m_miss), "stats",
          {hit_count, miss_count}, {16'(m_hits), 16'(m_miss)});
      chk(upd_valid == resp_valid && upd_hit == resp_hit && upd_line == resp_line,
          "upd_mirror", {upd_valid, upd_hit, upd_line},
          {resp_valid, resp_hit, resp_line});
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk(resp_valid && resp_hit == e.hit && resp_line == e.line, "resp",
            {resp_valid, resp_hit, resp_line}, {1'b1, e.hit, e.line});
        last_hit  = resp_hit;
        last_line = resp_line;
`ifdef LRU_CTRL_STATS_EN
        if (e.hit) begin
          if (m_hits != 16'hFFFF) m_hits++;
        end else begin
          if (m_miss != 16'hFFFF) m_miss++;
        end
`endif
      end else begin
        chk(!resp_valid, "resp_idle", resp_valid, 0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(req_ready, "ready_timeout", req_ready, 1);
  endtask

  // One request from IDLE; call and return at a negedge.
  task automatic do_req(input bit [7:0] tag, input bit [1:0] vic,
                        input int ack_dly, input bit flush_mid);
    bit       mh = 0;
    bit [1:0] ml = 0;
    bit       found = 0;
    exp_t     e;
    wait_ready();
    for (int i = 0; i < 4; i++)
      if (m_vld[i] && m_tag[i] == tag) begin mh = 1; ml = 2'(i); end
    if (!mh) begin
      for (int i = 0; i < 4; i++)
        if (!m_vld[i] && !found) begin found = 1; ml = 2'(i); end
      if (!found) ml = vic;
      m_tag[ml] = tag;
      m_vld[ml] = 1;
    end
    e.hit  = mh;
    e.line = ml;
    e.due  = mh ? cyc + 2 : cyc + 3 + ack_dly;
    exp_q.push_back(e);
    req_valid   = 1;
    req_tag     = tag;
    victim_line = vic;
    @(negedge clk);
    req_valid = 0;
    if (flush_mid) flush = 1;
    @(negedge clk);
    flush = 0;
    if (!mh) begin
      for (int k = 0; k <= ack_dly; k++) begin
        chk(mem_req && mem_tag == tag, "mem_req_hold", {mem_req, mem_tag}, {1'b1, tag});
        if (k == ack_dly) mem_ack = 1;
        @(negedge clk);
      end
      mem_ack = 0;
    end else begin
      chk(!mem_req, "no_mem_req_on_hit", mem_req, 0);
    end
    @(posedge clk);
    #1;
    chk(exp_q.size() == 0, "resp_seen", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_last(input bit h, input bit [1:0] l, input string name);
    chk(last_hit == h && last_line == l, name, {last_hit, last_line}, {h, l});
  endtask

  initial begin
    reset = 1; req_valid = 0; req_tag = 0; flush = 0;
    victim_line = 0; mem_ack = 0;
    for (int i = 0; i < 4; i++) begin m_tag[i] = 0; m_vld[i] = 0; end
    repeat (3) @(negedge clk);
    chk(req_ready && !resp_valid && !upd_valid && !mem_req && mem_tag == 0,
        "reset_outputs", {req_ready, resp_valid, upd_valid, mem_req, mem_tag},
        {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    chk(hit_count == 0 && miss_count == 0, "reset_stats",
        {hit_count, miss_count}, 0);
    reset = 0;
    @(negedge clk);

    do_req(8'h11, 2'd0, 2, 0);
    chk_last(0, 2'd0, "first_miss_line0");
    do_req(8'h22, 2'd0, 0, 0);
    do_req(8'h33, 2'd0, 1, 0);
    do_req(8'h44, 2'd0, 3, 0);
    chk_last(0, 2'd3, "fill_line3");

    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    chk(req_ready, "stray_ack_idle", req_ready, 1);

    do_req(8'h33, 2'd0, 0, 0);
    chk_last(1, 2'd2, "hit_33_line2");
    do_req(8'h55, 2'd1, 1, 0);
    chk_last(0, 2'd1, "victim_line1");
    do_req(8'h22, 2'd3, 0, 0);
    chk_last(0, 2'd3, "evicted_22_misses");
    do_req(8'h11, 2'd0, 0, 0);
    chk_last(1, 2'd0, "hit_11");
    do_req(8'h55, 2'd0, 0, 0);
    chk_last(1, 2'd1, "hit_55");

    flush = 1; req_valid = 1; req_tag = 8'h44;
    @(negedge clk);
    flush = 0; req_valid = 0;
    chk(req_ready, "flush_no_accept", req_ready, 1);
    for (int i = 0; i < 4; i++) m_vld[i] = 0;
    do_req(8'h11, 2'd2, 0, 0);
    chk_last(0, 2'd0, "post_flush_line0");
    do_req(8'h22, 2'd3, 1, 1);
    chk_last(0, 2'd1, "flush_busy_ignored");
    do_req(8'h11, 2'd0, 0, 0);
    chk_last(1, 2'd0, "hit_after_busy_flush");
`ifdef LRU_CTRL_STATS_EN
    chk(hit_count == 16'd4 && miss_count == 16'd8, "stats_literal",
        {hit_count, miss_count}, {16'd4, 16'd8});
`endif

    wait_ready();
    req_valid = 1; req_tag = 8'h66; victim_line = 0;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk(mem_req, "refill_entered", mem_req, 1);
    #2 reset = 1;
    #1;
    chk(!mem_req && req_ready && !resp_valid, "reset_mid_refill",
        {mem_req, req_ready, resp_valid}, 3'b010);
    for (int i = 0; i < 4; i++) m_vld[i] = 0;
    m_hits = 0;
    m_miss = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    do_req(8'h11, 2'd2, 0, 0);
    chk_last(0, 2'd0, "clean_after_reset");

`ifdef LRU_CTRL_STATS_EN
    force dut.hit_cnt_q = 16'hFFFF;
    m_hits = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.hit_cnt_q;
    @(negedge clk);
    do_req(8'h11, 2'd0, 0, 0);
    chk(hit_count == 16'hFFFF, "hit_saturate", hit_count, 16'hFFFF);
`else
    chk(hit_count == 0 && miss_count == 0, "stats_disabled",
        {hit_count, miss_count}, 0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
